// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and helpers for the FIR output quantizer
package fir_pkg;

   // Width of the dropped-sample counter.
   localparam int DROP_CNT_W = 16;

   // Default FIR geometry the quantizer is normally built for.
   localparam int DEF_MULTBITS = 32;
   localparam int DEF_TAPS     = 401;

   // Accumulator width that holds the sum of `taps` products without overflow.
   function automatic int accu_bits(input int multbits, input int taps);
      return multbits + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - first-word-fall-through synchronous FIFO
module fir_sync_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_rd;
   logic             w_do_wr;

   // Pointers carry one extra wrap bit so the difference is the occupancy.
   assign fill  = r_wr_ptr - r_rd_ptr;
   assign full  = (fill == C_FULL);
   assign empty = (fill == '0);

   // A read while empty is ignored; a write while full only lands if a read frees a slot.
   assign w_do_rd = rd_en && !empty;
   assign w_do_wr = wr_en && (!full || w_do_rd);

   // Head of the queue is presented combinationally (fall-through).
   assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

   // Storage array: written only on an accepted push, never reset.
   always_ff @(posedge clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Pointer advance; reset empties the queue immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fir_output_quantizer.sv
// rtl/fir_output_quantizer.sv - round, shift, saturate and buffer FIR accumulator output
module fir_output_quantizer
   import fir_pkg::*;
#(
   parameter int ACCUBITS = accu_bits(DEF_MULTBITS, DEF_TAPS),
   parameter int OUTBITS  = 16,
   parameter int SHIFT    = 24,
   parameter int DEPTH    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [ACCUBITS-1:0]   in_data,
   input  logic                         in_valid,
   output logic signed [OUTBITS-1:0]    out_data,
   output logic                         out_sat,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH):0]       fill,
   output logic                         overflow,
   output logic [DROP_CNT_W-1:0]        drop_count,
   input  logic                         clr_status
);

   typedef struct packed {
      logic                       sat;
      logic signed [OUTBITS-1:0]  data;
   } q_sample_t;

   localparam int QW = OUTBITS + 1;

   // Output range expressed at the widened rounding width for signed compares.
   localparam logic signed [ACCUBITS:0] C_MAX =
      {{(ACCUBITS + 2 - OUTBITS){1'b0}}, {(OUTBITS - 1){1'b1}}};
   localparam logic signed [ACCUBITS:0] C_MIN =
      {{(ACCUBITS + 2 - OUTBITS){1'b1}}, {(OUTBITS - 1){1'b0}}};
   localparam logic signed [OUTBITS-1:0] C_OUT_MAX = {1'b0, {(OUTBITS - 1){1'b1}}};
   localparam logic signed [OUTBITS-1:0] C_OUT_MIN = {1'b1, {(OUTBITS - 1){1'b0}}};

   // Stage 1: rounded sum, one bit wider so adding the half-LSB cannot wrap.
   logic                       r_v1;
   logic signed [ACCUBITS:0]   r_round;
   logic signed [ACCUBITS:0]   w_ext;
   logic [ACCUBITS:0]          w_round_inc;

   // Stage 2: quantized sample ready to be queued.
   logic                       r_v2;
   q_sample_t                  r_s2;
   logic signed [ACCUBITS:0]   w_shifted;
   q_sample_t                  w_s2_next;

   // FIFO side.
   logic [QW-1:0]              w_rd_data;
   q_sample_t                  w_head;
   logic                       w_full;
   logic                       w_empty;
   logic                       w_pop;
   logic                       w_drop;
   q_sample_t                  r_hold;

   // Status.
   logic                       r_overflow;
   logic [DROP_CNT_W-1:0]      r_drop_count;

   assign w_ext = {in_data[ACCUBITS-1], in_data};

   // Half an output LSB for round-half-up; nothing to add when there is no shift.
   generate
      if (SHIFT > 0) begin : g_round
         assign w_round_inc = {{ACCUBITS{1'b0}}, 1'b1} << (SHIFT - 1);
      end else begin : g_no_round
         assign w_round_inc = '0;
      end
   endgenerate

   // Stage 1 register: sign-extend and add the rounding increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1    <= 1'b0;
         r_round <= '0;
      end else begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_round <= w_ext + w_round_inc;
         end
      end
   end

   assign w_shifted = r_round >>> SHIFT;

   // Clamp the shifted value into the signed output range and flag clipping.
   always_comb begin
      w_s2_next.sat  = 1'b0;
      w_s2_next.data = w_shifted[OUTBITS-1:0];
      if (w_shifted > C_MAX) begin
         w_s2_next.sat  = 1'b1;
         w_s2_next.data = C_OUT_MAX;
      end else if (w_shifted < C_MIN) begin
         w_s2_next.sat  = 1'b1;
         w_s2_next.data = C_OUT_MIN;
      end
   end

   // Stage 2 register: quantized sample; valids advance every cycle, no stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v2 <= 1'b0;
         r_s2 <= '0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_s2 <= w_s2_next;
         end
      end
   end

   // Pop only when something is presented; a push into a full queue survives only alongside a pop.
   assign w_pop  = out_ready && !w_empty;
   assign w_drop = r_v2 && w_full && !w_pop;

   fir_sync_fifo #(
      .WIDTH (QW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (r_v2),
      .wr_data (r_s2),
      .rd_en   (w_pop),
      .rd_data (w_rd_data),
      .full    (w_full),
      .empty   (w_empty),
      .fill    (fill)
   );

   assign w_head = w_rd_data;

   // Remember the last head shown so the outputs hold steady while the queue is empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold <= '0;
      end else if (!w_empty) begin
         r_hold <= w_head;
      end
   end

   assign out_valid = !w_empty;
   assign out_data  = w_empty ? r_hold.data : w_head.data;
   assign out_sat   = w_empty ? r_hold.sat  : w_head.sat;

   // Sticky overflow and saturating drop counter; a drop in the clear cycle wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (clr_status) begin
            r_drop_count <= DROP_CNT_W'(1);
         end else if (r_drop_count != '1) begin
            r_drop_count <= r_drop_count + 1'b1;
         end
      end else if (clr_status) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end
   end

   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;

endmodule

// File: tb/tb_fir_output_quantizer.sv
// tb/tb_fir_output_quantizer.sv - scoreboard bench for fir_output_quantizer
module tb_fir_output_quantizer;

   localparam int AB = 41;
   localparam int OB = 16;

   typedef struct {
      logic              sat;
      logic signed [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic signed [AB-1:0] in_data;
   logic                 in_valid;
   logic signed [OB-1:0] out_data;
   logic                 out_sat;
   logic                 out_valid;
   logic                 out_ready;
   logic [3:0]           fill;
   logic                 overflow;
   logic [15:0]          drop_count;
   logic                 clr_status;

   logic signed [AB-1:0] in_data_z;
   logic                 in_valid_z;
   logic signed [OB-1:0] out_data_z;
   logic                 out_sat_z;
   logic                 out_valid_z;
   logic                 out_ready_z;
   logic [3:0]           fill_z;
   logic                 overflow_z;
   logic [15:0]          drop_count_z;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q_exp[$];
   exp_t q_exp_z[$];
   exp_t m_e;
   exp_t m_ez;

   fir_output_quantizer #(.ACCUBITS(AB), .OUTBITS(OB), .SHIFT(24), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
      .fill(fill), .overflow(overflow), .drop_count(drop_count), .clr_status(clr_status)
   );

   fir_output_quantizer #(.ACCUBITS(AB), .OUTBITS(OB), .SHIFT(0), .DEPTH(8)) dut_z (
      .clk(clk), .rst(rst), .in_data(in_data_z), .in_valid(in_valid_z),
      .out_data(out_data_z), .out_sat(out_sat_z), .out_valid(out_valid_z), .out_ready(out_ready_z),
      .fill(fill_z), .overflow(overflow_z), .drop_count(drop_count_z), .clr_status(1'b0)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic signed [AB-1:0] mk(input int k);
      logic signed [AB-1:0] v;
      v = AB'(k);
      return v <<< 24;
   endfunction

   task automatic push(input int v, input bit s);
      exp_t e;
      e.data = 16'(v);
      e.sat  = s;
      q_exp.push_back(e);
   endtask

   task automatic push_z(input int v, input bit s);
      exp_t e;
      e.data = 16'(v);
      e.sat  = s;
      q_exp_z.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic signed [AB-1:0] v);
      in_valid = 1'b1;
      in_data  = v;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_z(input logic signed [AB-1:0] v);
      in_valid_z = 1'b1;
      in_data_z  = v;
      tick();
      in_valid_z = 1'b0;
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (q_exp.size() == 0 && !out_valid) break;
         tick();
      end
      check(name, (q_exp.size() == 0 && !out_valid), 1);
   endtask

   // Scoreboard monitor for the default build.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0d expected none", out_data);
         end else begin
            m_e = q_exp.pop_front();
            check("out_data", out_data, m_e.data);
            check("out_sat", out_sat, m_e.sat);
         end
      end
   end

   // Scoreboard monitor for the SHIFT=0 build.
   always @(negedge clk) begin
      if (!rst && out_valid_z && out_ready_z) begin
         if (q_exp_z.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output_z: got %0d expected none", out_data_z);
         end else begin
            m_ez = q_exp_z.pop_front();
            check("out_data_z", out_data_z, m_ez.data);
            check("out_sat_z", out_sat_z, m_ez.sat);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_status = 1'b0;
      in_valid_z = 1'b0; in_data_z = '0; out_ready_z = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_fill", fill, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_count", drop_count, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Latency: 1.5 rounds up to 2, visible exactly 3 cycles later.
      push(2, 0);
      send(41'sd25165824);
      @(negedge clk); check("lat_cycle1", out_valid, 0);
      @(posedge clk); @(negedge clk); check("lat_cycle2", out_valid, 0);
      @(posedge clk); @(negedge clk); check("lat_cycle3", out_valid, 1);
      @(posedge clk); #1;
      drain("drain_latency");

      // Rounding and saturation vectors back to back.
      push(-1, 0);     send(-41'sd25165824);
      push(1, 0);      send(41'sd16777215);
      push(0, 0);      send(41'sd8388607);
      push(32767, 1);  send(mk(40000));
      push(-32768, 1); send(mk(-40000));
      push(32767, 0);  send(mk(32767));
      push(-32768, 0); send(mk(-32768));
      drain("drain_round_sat");

      // SHIFT=0 build: pass-through with saturation only.
      push_z(300, 0);     send_z(41'sd300);
      push_z(32767, 1);   send_z(41'sd70000);
      push_z(-32768, 1);  send_z(-41'sd70000);
      repeat (8) tick();
      check("drain_shift0", (q_exp_z.size() == 0 && !out_valid_z), 1);

      // Overflow: 10 inputs into a stalled 8-deep queue.
      out_ready = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k <= 8) push(k, 0);
         send(mk(k));
      end
      repeat (3) tick();
      check("ovf_fill", fill, 8);
      check("ovf_overflow", overflow, 1);
      check("ovf_drop_count", drop_count, 2);
      clr_status = 1'b1; tick(); clr_status = 1'b0;
      check("clr_overflow", overflow, 0);
      check("clr_drop_count", drop_count, 0);
      drain("drain_overflow");

      // Full queue with a pop every cycle while pushes keep arriving.
      for (int c = 0; c < 16; c++) begin
         in_valid  = (c < 14);
         in_data   = mk(11 + c);
         if (c < 14) push(11 + c, 0);
         out_ready = (c >= 10);
         @(negedge clk);
         if (c >= 10) check("full_pop_fill", fill, 8);
         tick();
      end
      in_valid = 1'b0;
      drain("drain_full_pop");
      check("full_pop_drops", drop_count, 0);
      check("full_pop_overflow", overflow, 0);

      // Clear in the same cycle as a drop: the drop wins.
      out_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         in_valid   = (c < 10);
         in_data    = mk(31 + c);
         if (c < 8) push(31 + c, 0);
         clr_status = (c == 11);
         tick();
      end
      in_valid = 1'b0; clr_status = 1'b0;
      check("clrdrop_overflow", overflow, 1);
      check("clrdrop_count", drop_count, 1);
      check("clrdrop_fill", fill, 8);
      clr_status = 1'b1; tick(); clr_status = 1'b0;
      drain("drain_clrdrop");

      // Asynchronous reset with 5 buffered and 2 in flight.
      out_ready = 1'b0;
      for (int c = 0; c < 7; c++) send(mk(50 + c));
      check("pre_rst_fill", fill, 5);
      #3 rst = 1'b1;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_fill", fill, 0);
      check("async_rst_data", out_data, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      push(7, 0);
      send(mk(7));
      drain("drain_after_rst");
      repeat (4) tick();
      check("post_rst_quiet", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_output_quantizer.md
Name: fir_output_quantizer

Overview:
- Sits directly downstream of the FIR adder-tree accumulator and consumes its full-precision sum and valid strobe.
- Rounds and right-shifts the sum to the output Q-format, then saturates it to OUTBITS.
- Buffers results in a small FIFO behind a valid/ready handshake, because the accumulator cannot be back-pressured.
- Reports samples lost to FIFO overflow.

Parameters:
- ACCUBITS, 41, width of signed accumulator sum (MULTBITS 32 + clog2(401 taps)).
- OUTBITS, 16, width of signed output sample.
- SHIFT, 24, arithmetic right-shift applied after rounding; 0 means no rounding and no shift.
- DEPTH, 8, FIFO depth in entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_data  in  ACCUBITS  signed accumulator sum
- in_valid  in  1  in_data is valid this cycle; no ready is returned
- out_data  out  OUTBITS  signed quantized sample at FIFO head
- out_sat  out  1  head sample was saturated
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this cycle
- fill  out  clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: at least one sample dropped
- drop_count  out  16  dropped samples; saturates at 0xFFFF
- clr_status  in  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (asynchronous, rst=1): all of the following go to 0: pipeline valids, FIFO pointers, fill, out_valid, out_data, out_sat, overflow, drop_count. Reset mid-stream discards all in-flight and buffered samples. The first accepted input after rst deasserts is the first one processed.
- Stage 1 (register at edge ending cycle N, where in_valid=1): r = sign_extend(in_data, ACCUBITS+1) + (SHIFT>0 ? 2^(SHIFT-1) : 0). Rounding is round-half-up toward +inf. The extra bit means r never overflows.
- Stage 2 (edge ending N+1): q = r >>> SHIFT (arithmetic).
  - q > 2^(OUTBITS-1)-1 gives q = max and sat = 1.
  - q < -2^(OUTBITS-1) gives q = min and sat = 1.
  - Otherwise sat = 0.
- Stage 3 (edge ending N+2): {sat, q} is written to the FIFO. If the FIFO was empty, out_valid=1 in cycle N+3. Fixed latency is 3 cycles to head.
- Stage valid bits advance every cycle unconditionally. There is no stall.
- The FIFO is first-word-fall-through: out_data/out_sat show the head whenever out_valid=1. When out_valid=0, out_data and out_sat hold their last value (0 after reset).
- Pop occurs when out_valid && out_ready. out_ready while empty is ignored.
- Push when full:
  - If a pop occurs the same cycle, push and pop both happen, fill is unchanged, and nothing is dropped.
  - Otherwise the sample is discarded, overflow is set, and drop_count increments (holds at 0xFFFF).
- Push while empty with out_ready=1: the sample is written. It is not visible until the next cycle, so no bypass.
- Pointers wrap modulo DEPTH. fill = wr_ptr - rd_ptr using clog2(DEPTH)+1-bit pointers. Full is fill==DEPTH; empty is fill==0.
- clr_status: clears overflow and drop_count at the next edge. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_count=1.
- Back-to-back in_valid every cycle is supported at full throughput.

Decomposition:
- fir_pkg holds:
  - function accu_bits(multbits, taps) = multbits + $clog2(taps)
  - typedef q_sample_t struct {logic sat; logic signed [OUTBITS-1:0] data} (parameterized via localparam in the module)
  - constant DROP_CNT_W = 16
- Sub-module fir_sync_fifo has parameters WIDTH and DEPTH, and ports clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty, fill. It is instantiated once with WIDTH = OUTBITS+1.
- Rounding and saturation logic stays in the top module.

Test Plan:
- Rounding (defaults): in_data = 25165824 (1.5·2^24) gives out_data=2, sat=0, out_valid exactly 3 cycles after in_valid. in_data = -25165824 gives -1. in_data = 16777215 gives 1. in_data = 8388607 gives 0.
- Saturation: in_data = 40000·2^24 gives 32767, sat=1. in_data = -40000·2^24 gives -32768, sat=1. in_data = 32767·2^24 gives 32767, sat=0.
- Overflow: out_ready=0 with 10 consecutive valid inputs 1..10 (·2^24). Then fill=8, overflow=1, drop_count=2. Draining yields 1..8 in order, after which out_valid=0.
- Full with simultaneous pop: fill FIFO to 8, then hold out_ready=1 while streaming. No drops and fill stays 8. Pulse clr_status with no drop: overflow=0, drop_count=0. Pulse clr_status coincident with a drop: drop_count=1.
- Reset mid-operation: 5 samples buffered plus 2 in the pipeline, then assert rst asynchronously between edges. Outputs clear immediately. After release, a new sample 7·2^24 appears as the only output, value 7.
- SHIFT=0, OUTBITS=16 build: in_data=300 gives 300. in_data=70000 gives 32767 with sat=1.
